// File: rtl/cache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : cache_line_fill
//  Description : Fetches one cache line from a word-wide memory port after a
//                miss. Words are requested critical-word-first and wrap within
//                the line. Only one request is outstanding at a time. Each
//                returned word is forwarded to the cache as a registered
//                one-cycle fill pulse. A watchdog aborts the line when memory
//                stops answering.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_line_fill #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_SIZE      = 16,   // bytes per line, power of two
   parameter int OFFSET_BITS    = 4,    // log2(LINE_SIZE)
   parameter int TIMEOUT_CYCLES = 255   // max cycles waiting for one response
) (
   input  logic                  clk,
   input  logic                  reset,
   // miss interface from the cache
   input  logic                  miss_valid,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   output logic                  miss_ready,
   // memory request channel
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   // memory response channel
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   // fill interface toward the cache
   output logic                  fill_valid,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  fill_last,
   output logic                  fill_err
);

   // ------------------------------------------------------------------------
   // Derived sizes
   // ------------------------------------------------------------------------
   // A line holds WORDS 4-byte words; the word index inside the line is the
   // address slice [OFFSET_BITS-1:2], so IDX_BITS wide. The line-relative
   // index arithmetic relies on WORDS being a power of two so that the
   // natural wrap of an IDX_BITS-wide adder equals "mod WORDS".
   localparam int WORDS    = LINE_SIZE / 4;
   localparam int IDX_BITS = OFFSET_BITS - 2;
   localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS;

   // The wait counter only ever holds 0 .. TIMEOUT_CYCLES-1: the cycle in
   // which it shows TIMEOUT_CYCLES-1 is the last one a response may arrive.
   localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [IDX_BITS-1:0] LAST_WORD    = IDX_BITS'(WORDS - 1);
   localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   logic [1:0]          state;
   logic [1:0]          state_next;

   // ------------------------------------------------------------------------
   // Line context captured when a miss is accepted
   // ------------------------------------------------------------------------
   logic [TAG_BITS-1:0] line_tag;     // miss_addr above the line offset
   logic [IDX_BITS-1:0] start_idx;    // critical word index
   logic [IDX_BITS-1:0] word_cnt;     // k: how many words already returned
   logic [CNT_BITS-1:0] wait_cnt;     // cycles spent in the current WAIT_RSP

   // The byte-within-word bits of the miss address never matter: every
   // request and fill address is word aligned.
   logic [1:0]          unused_byte_sel;
   assign unused_byte_sel = miss_addr[1:0];

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                  accept_miss;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  last_word;
   logic                  timeout;
   logic [IDX_BITS-1:0]   word_idx;
   logic [ADDR_WIDTH-1:0] cur_addr;

   // Handshakes and the critical-word-first address of the current word.
   // word_idx wraps naturally inside the line, so the k-th request lands on
   // (start + k) mod WORDS. cur_addr stays constant through ISSUE and
   // WAIT_RSP of one word because word_cnt only advances on a response,
   // which keeps the request address stable under back-pressure and lets
   // the fill reuse it as the matching address.
   always_comb begin
      accept_miss = (state == ST_IDLE) && miss_valid;
      req_fire    = (state == ST_ISSUE) && mem_req_ready;
      rsp_fire    = (state == ST_WAIT_RSP) && mem_rsp_valid;
      last_word   = (word_cnt == LAST_WORD);
      // A response arriving in the final allowed cycle takes priority.
      timeout     = (state == ST_WAIT_RSP) && !mem_rsp_valid &&
                    (wait_cnt == TIMEOUT_LAST);
      word_idx    = start_idx + word_cnt;
      cur_addr    = {line_tag, word_idx, 2'b00};
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one request in flight, one word per ISSUE/WAIT_RSP
   // round trip, a single DONE cycle before the next miss can be taken.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept_miss) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (req_fire) begin
               state_next = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_fire) begin
               state_next = last_word ? ST_DONE : ST_ISSUE;
            end else if (timeout) begin
               state_next = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State-decoded outputs: ready only in IDLE, request only in ISSUE. The
   // request address is zeroed outside ISSUE so the bus is quiet when idle.
   always_comb begin
      miss_ready    = (state == ST_IDLE);
      mem_req_valid = (state == ST_ISSUE);
      mem_req_addr  = (state == ST_ISSUE) ? cur_addr : '0;
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------

   // Line context, word counter and response watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_tag  <= '0;
         start_idx <= '0;
         word_cnt  <= '0;
         wait_cnt  <= '0;
      end else begin
         if (accept_miss) begin
            line_tag  <= miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
            start_idx <= miss_addr[OFFSET_BITS-1:2];
            word_cnt  <= '0;
            wait_cnt  <= '0;
         end
         // Every entry into WAIT_RSP starts the watchdog from zero.
         if (req_fire) begin
            wait_cnt <= '0;
         end
         if (rsp_fire) begin
            word_cnt <= word_cnt + 1'b1;
         end else if ((state == ST_WAIT_RSP) && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Registered fill port: one pulse per accepted response, with address,
   // data and last flag forced to zero whenever no fill is being presented.
   // The abort pulse is registered the same way so it lines up with the
   // first IDLE cycle after the timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_valid <= 1'b0;
         fill_addr  <= '0;
         fill_data  <= '0;
         fill_last  <= 1'b0;
         fill_err   <= 1'b0;
      end else begin
         fill_valid <= rsp_fire;
         fill_addr  <= rsp_fire ? cur_addr : '0;
         fill_data  <= rsp_fire ? mem_rsp_data : '0;
         fill_last  <= rsp_fire && last_word;
         fill_err   <= timeout;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_line_fill
//  Description : Self-checking bench for cache_line_fill. A responder model
//                plays the memory; expected requests and fills are queued
//                when each miss is driven and matched against what the
//                design produces.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_line_fill;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 12;
   localparam int WORDS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          miss_valid;
   logic [AW-1:0] miss_addr;
   logic          miss_ready;
   logic          mem_req_valid;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rsp_data;
   logic          fill_valid;
   logic [AW-1:0] fill_addr;
   logic [DW-1:0] fill_data;
   logic          fill_last;
   logic          fill_err;

   cache_line_fill #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .LINE_SIZE      (16),
      .OFFSET_BITS    (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .miss_valid    (miss_valid),
      .miss_addr     (miss_addr),
      .miss_ready    (miss_ready),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .fill_valid    (fill_valid),
      .fill_addr     (fill_addr),
      .fill_data     (fill_data),
      .fill_last     (fill_last),
      .fill_err      (fill_err)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Scoreboard and observation state
   // ------------------------------------------------------------------------
   int          checks = 0;
   int          errors = 0;

   logic [31:0] exp_req[$];
   logic [31:0] req_obs[$];
   logic [64:0] exp_fill[$];     // {last, addr, data}
   logic [64:0] fill_obs[$];

   int          idle_nz;         // cycles with fill_valid=0 but non-zero payload
   int          err_cnt;         // cycles with fill_err high
   int          err_ready_bad;   // fill_err seen while miss_ready low
   int          unstable_cnt;    // request address changed while stalled
   int          hs_count;        // accepted requests

   // responder controls and state
   int          stall_left;
   int          no_rsp_idx;
   int          rsp_delay;
   bit          inject_rsp;
   bit          pend;
   bit          acc;
   bit          in_req;
   int          pend_wait;
   logic [31:0] pend_data;
   logic [31:0] acc_addr;
   logic [31:0] held_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F96;
   endfunction

   // Expected traffic of one line: n_req requests, the first n_fill of
   // which produce fills.
   task automatic push_line(input logic [31:0] a, input int n_req, input int n_fill);
      logic [31:0] base;
      logic [31:0] wa;
      int          start;
      base  = a & 32'hFFFF_FFF0;
      start = int'(a[3:2]);
      for (int k = 0; k < n_req; k++) begin
         wa = base + 32'(((start + k) % WORDS) * 4);
         exp_req.push_back(wa);
         if (k < n_fill) begin
            exp_fill.push_back({(k == WORDS - 1) ? 1'b1 : 1'b0, wa, mem_word(wa)});
         end
      end
   endtask

   task automatic clear_obs();
      exp_req.delete();
      req_obs.delete();
      exp_fill.delete();
      fill_obs.delete();
      idle_nz       = 0;
      err_cnt       = 0;
      err_ready_bad = 0;
      unstable_cnt  = 0;
      hs_count      = 0;
      stall_left    = 0;
      no_rsp_idx    = -1;
      rsp_delay     = 0;
      inject_rsp    = 1'b0;
      pend          = 1'b0;
      acc           = 1'b0;
      in_req        = 1'b0;
      pend_wait     = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   // One clock: memory model reacts and DUT outputs are recorded #1 after
   // the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (acc) begin
         acc = 1'b0;
         hs_count++;
         if (hs_count - 1 != no_rsp_idx) begin
            pend      = 1'b1;
            pend_wait = rsp_delay;
            pend_data = mem_word(acc_addr);
         end
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (pend) begin
         if (pend_wait == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_data;
            pend          = 1'b0;
         end else begin
            pend_wait--;
         end
      end else if (inject_rsp) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 32'hDEAD_BEEF;
         inject_rsp    = 1'b0;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid === 1'b1) begin
         if (!in_req) begin
            in_req    = 1'b1;
            held_addr = mem_req_addr;
            req_obs.push_back(mem_req_addr);
         end else if (mem_req_addr !== held_addr) begin
            unstable_cnt++;
         end
         if (stall_left > 0) begin
            stall_left--;
         end else begin
            mem_req_ready = 1'b1;
            acc           = 1'b1;
            acc_addr      = mem_req_addr;
            in_req        = 1'b0;
         end
      end
      if (fill_valid === 1'b1) begin
         fill_obs.push_back({fill_last, fill_addr, fill_data});
      end else if (fill_addr !== '0 || fill_data !== '0 || fill_last !== 1'b0) begin
         idle_nz++;
      end
      if (fill_err === 1'b1) begin
         err_cnt++;
         if (miss_ready !== 1'b1) err_ready_bad++;
      end
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({miss_ready, mem_req_valid, fill_valid, fill_last, fill_err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 10000",
                  {miss_ready, mem_req_valid, fill_valid, fill_last, fill_err});
      end
      checks++;
      if ({mem_req_addr, fill_addr, fill_data} !== 96'd0) begin
         errors++;
         $display("FAIL reset_bus: got %h %h %h want 0", mem_req_addr, fill_addr, fill_data);
      end
      reset = 1'b0;
      clear_obs();
      tick();
   endtask

   task automatic test_basic_fill();
      logic [31:0] ea, ga;
      logic [64:0] ef, gf;
      int          n;
      clear_obs();
      push_line(32'h1000_0008, 4, 4);
      miss_valid = 1'b1; miss_addr = 32'h1000_0008;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (miss_ready !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (n != 2 * WORDS + 1) begin
         errors++; $display("FAIL basic_latency: got %0d want %0d", n, 2 * WORDS + 1);
      end
      while (exp_req.size() > 0) begin
         ea = exp_req.pop_front(); checks++;
         if (req_obs.size() > 0) ga = req_obs.pop_front(); else ga = 'x;
         if (ga !== ea) begin errors++; $display("FAIL basic_req: got %h want %h", ga, ea); end
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL basic_fill: got %h want %h", gf, ef); end
      end
      checks++;
      if (req_obs.size() + fill_obs.size() + err_cnt + idle_nz != 0) begin
         errors++;
         $display("FAIL basic_extra: got req %0d fill %0d err %0d idle_nz %0d want 0",
                  req_obs.size(), fill_obs.size(), err_cnt, idle_nz);
      end
   endtask

   task automatic test_req_stall();
      logic [31:0] ea, ga;
      logic [64:0] ef, gf;
      int          n;
      clear_obs();
      stall_left = 3;
      push_line(32'h1000_0008, 4, 4);
      miss_valid = 1'b1; miss_addr = 32'h1000_0008;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (miss_ready !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (unstable_cnt != 0 || hs_count != WORDS) begin
         errors++;
         $display("FAIL stall_hold: got unstable %0d accepted %0d want 0 %0d",
                  unstable_cnt, hs_count, WORDS);
      end
      while (exp_req.size() > 0) begin
         ea = exp_req.pop_front(); checks++;
         if (req_obs.size() > 0) ga = req_obs.pop_front(); else ga = 'x;
         if (ga !== ea) begin errors++; $display("FAIL stall_req: got %h want %h", ga, ea); end
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL stall_fill: got %h want %h", gf, ef); end
      end
      checks++;
      if (req_obs.size() + fill_obs.size() != 0) begin
         errors++; $display("FAIL stall_extra: got req %0d fill %0d want 0 0",
                            req_obs.size(), fill_obs.size());
      end
   endtask

   task automatic test_idle_rsp();
      clear_obs();
      inject_rsp = 1'b1;
      repeat (4) tick();
      checks++;
      if (fill_obs.size() != 0 || idle_nz != 0) begin
         errors++; $display("FAIL idle_rsp_fill: got %0d fills want 0", fill_obs.size());
      end
      checks++;
      if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
         errors++; $display("FAIL idle_rsp_state: got ready %b req %b want 1 0",
                            miss_ready, mem_req_valid);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] ea, ga;
      logic [64:0] ef, gf;
      int          n;
      clear_obs();
      no_rsp_idx = 1;
      push_line(32'h2000_0004, 2, 1);
      miss_valid = 1'b1; miss_addr = 32'h2000_0004;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (miss_ready !== 1'b1 && n < TO + 40) begin tick(); n++; end
      checks++;
      if (err_cnt != 1 || err_ready_bad != 0) begin
         errors++; $display("FAIL timeout_err: got pulses %0d ready_low %0d want 1 0",
                            err_cnt, err_ready_bad);
      end
      repeat (5) tick();
      checks++;
      if (err_cnt != 1 || hs_count != 2 || miss_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_quiet: got pulses %0d reqs %0d ready %b want 1 2 1",
                            err_cnt, hs_count, miss_ready);
      end
      while (exp_req.size() > 0) begin
         ea = exp_req.pop_front(); checks++;
         if (req_obs.size() > 0) ga = req_obs.pop_front(); else ga = 'x;
         if (ga !== ea) begin errors++; $display("FAIL timeout_req: got %h want %h", ga, ea); end
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL timeout_fill: got %h want %h", gf, ef); end
      end
      checks++;
      if (req_obs.size() + fill_obs.size() != 0) begin
         errors++; $display("FAIL timeout_extra: got req %0d fill %0d want 0 0",
                            req_obs.size(), fill_obs.size());
      end
   endtask

   task automatic test_timeout_boundary();
      logic [64:0] ef, gf;
      int          n;
      // Response in the last allowed wait cycle of every word: line completes.
      clear_obs();
      rsp_delay = TO - 1;
      push_line(32'h3000_000C, 4, 4);
      miss_valid = 1'b1; miss_addr = 32'h3000_000C;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (miss_ready !== 1'b1 && n < 4 * (TO + 4) + 20) begin tick(); n++; end
      checks++;
      if (err_cnt != 0) begin
         errors++; $display("FAIL bound_win_err: got %0d pulses want 0", err_cnt);
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL bound_win_fill: got %h want %h", gf, ef); end
      end
      // One cycle later than that: the line is aborted with no fill.
      clear_obs();
      rsp_delay = TO;
      miss_valid = 1'b1; miss_addr = 32'h3000_000C;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (miss_ready !== 1'b1 && n < TO + 40) begin tick(); n++; end
      repeat (4) tick();
      checks++;
      if (err_cnt != 1 || fill_obs.size() != 0 || hs_count != 1) begin
         errors++; $display("FAIL bound_late: got pulses %0d fills %0d reqs %0d want 1 0 1",
                            err_cnt, fill_obs.size(), hs_count);
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] ea, ga;
      logic [64:0] ef, gf;
      int          n;
      clear_obs();
      no_rsp_idx = 2;
      push_line(32'h4000_0000, 3, 2);
      miss_valid = 1'b1; miss_addr = 32'h4000_0000;
      tick();
      miss_valid = 1'b0;
      n = 0;
      while (hs_count < 3 && n < 60) begin tick(); n++; end
      checks++;
      if (hs_count != 3) begin
         errors++; $display("FAIL rst_mid_reach: got %0d reqs want 3", hs_count);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({miss_ready, mem_req_valid, fill_valid, fill_last, fill_err} !== 5'b10000) begin
         errors++;
         $display("FAIL rst_mid_ctrl: got %b want 10000",
                  {miss_ready, mem_req_valid, fill_valid, fill_last, fill_err});
      end
      checks++;
      if ({mem_req_addr, fill_addr, fill_data} !== 96'd0) begin
         errors++;
         $display("FAIL rst_mid_bus: got %h %h %h want 0", mem_req_addr, fill_addr, fill_data);
      end
      tick();
      inject_rsp = 1'b1;
      repeat (5) tick();
      while (exp_req.size() > 0) begin
         ea = exp_req.pop_front(); checks++;
         if (req_obs.size() > 0) ga = req_obs.pop_front(); else ga = 'x;
         if (ga !== ea) begin errors++; $display("FAIL rst_mid_req: got %h want %h", ga, ea); end
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL rst_mid_fill: got %h want %h", gf, ef); end
      end
      checks++;
      if (req_obs.size() + fill_obs.size() + idle_nz != 0 || miss_ready !== 1'b1) begin
         errors++; $display("FAIL rst_mid_after: got req %0d fill %0d idle_nz %0d ready %b want 0 0 0 1",
                            req_obs.size(), fill_obs.size(), idle_nz, miss_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea, ga;
      logic [64:0] ef, gf;
      int          n;
      clear_obs();
      push_line(32'h1000_0008, 4, 4);
      push_line(32'h5000_0034, 4, 4);
      miss_valid = 1'b1; miss_addr = 32'h1000_0008;
      tick();
      miss_addr = 32'h5000_0034;
      n = 0;
      while (miss_ready !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (req_obs.size() != WORDS || fill_obs.size() != WORDS) begin
         errors++; $display("FAIL b2b_first_done: got req %0d fill %0d want %0d %0d",
                            req_obs.size(), fill_obs.size(), WORDS, WORDS);
      end
      tick();
      miss_valid = 1'b0;
      checks++;
      if (miss_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got ready %b want 0", miss_ready);
      end
      n = 0;
      while (miss_ready !== 1'b1 && n < 100) begin tick(); n++; end
      repeat (2) tick();
      while (exp_req.size() > 0) begin
         ea = exp_req.pop_front(); checks++;
         if (req_obs.size() > 0) ga = req_obs.pop_front(); else ga = 'x;
         if (ga !== ea) begin errors++; $display("FAIL b2b_req: got %h want %h", ga, ea); end
      end
      while (exp_fill.size() > 0) begin
         ef = exp_fill.pop_front(); checks++;
         if (fill_obs.size() > 0) gf = fill_obs.pop_front(); else gf = 'x;
         if (gf !== ef) begin errors++; $display("FAIL b2b_fill: got %h want %h", gf, ef); end
      end
      checks++;
      if (req_obs.size() + fill_obs.size() != 0) begin
         errors++; $display("FAIL b2b_extra: got req %0d fill %0d want 0 0",
                            req_obs.size(), fill_obs.size());
      end
   endtask

   initial begin
      reset         = 1'b1;
      miss_valid    = 1'b0;
      miss_addr     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      clear_obs();
      test_reset();
      test_basic_fill();
      test_req_stall();
      test_idle_rsp();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid_fill();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 SHALL take ADDR_WIDTH, DATA_WIDTH, LINE_SIZE, OFFSET_BITS from parameters_defn; WORDS = LINE_SIZE/4 (4-byte words).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles waiting for one memory response.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port miss_valid  input  1  cache reports a miss needing a line fill.
REQ-006 SHALL have port miss_addr  input  ADDR_WIDTH  byte address of the missing access.
REQ-007 SHALL have port miss_ready  output  1  high only in IDLE.
REQ-008 SHALL have port mem_req_valid  output  1  word read request to memory.
REQ-009 SHALL have port mem_req_addr  output  ADDR_WIDTH  word-aligned request address.
REQ-010 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-011 SHALL have port mem_rsp_valid  input  1  memory returns one word.
REQ-012 SHALL have port mem_rsp_data  input  DATA_WIDTH  returned word.
REQ-013 SHALL have port fill_valid  output  1  one-cycle pulse, fill word toward the cache.
REQ-014 SHALL have port fill_addr  output  ADDR_WIDTH  word-aligned address of the fill word.
REQ-015 SHALL have port fill_data  output  DATA_WIDTH  fill word.
REQ-016 SHALL have port fill_last  output  1  high with the final fill word of a line.
REQ-017 SHALL have port fill_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: when miss_valid && miss_ready, go to ISSUE.
- ISSUE: when mem_req_valid && mem_req_ready, go to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, go to ISSUE, or to DONE if this was the last word.
- DONE: go to IDLE after one cycle.
REQ-019 SHALL latch miss_addr on acceptance; base = miss_addr with bits [OFFSET_BITS-1:0] cleared; start = miss_addr[OFFSET_BITS-1:2].
REQ-020 SHALL request words critical-word-first: k-th request (k = 0..WORDS-1) address = base + (((start+k) mod WORDS) << 2), wrapping within the line, bits [1:0] = 0.
REQ-021 SHALL keep at most one request outstanding.
- mem_req_valid is high exactly in ISSUE.
- mem_req_addr is held stable while mem_req_valid && !mem_req_ready.
REQ-022 SHALL register each accepted response: fill_valid = 1 on the cycle after mem_rsp_valid in WAIT_RSP.
- fill_data = mem_rsp_data.
- fill_addr = the matching request address.
- fill_last = 1 for k = WORDS-1.
REQ-023 SHALL ignore mem_rsp_valid outside WAIT_RSP (no fill, no state change).
REQ-024 SHALL ignore miss_valid while not in IDLE; the upstream cache holds miss_valid until it sees miss_ready.
REQ-025 SHALL count WAIT_RSP cycles, reset to 0 on each entry. If the count reaches TIMEOUT_CYCLES without mem_rsp_valid: pulse fill_err for one cycle, go to IDLE, issue no further requests or fills for that line.
REQ-026 SHALL let a mem_rsp_valid arriving on the cycle the count reaches TIMEOUT_CYCLES win: the word is accepted, no error.
REQ-027 SHALL drive fill_addr and fill_data to 0 whenever fill_valid is 0.
REQ-028 SHALL accept a new miss no earlier than the cycle after DONE; the line-fill latency floor is 2*WORDS+2 cycles from acceptance to the DONE exit with zero-wait memory.

Reset
REQ-029 SHALL, when reset is high at a clock edge, enter IDLE and clear word and timeout counters.
- miss_ready = 1.
- mem_req_valid, fill_valid, fill_last, fill_err = 0.
- mem_req_addr, fill_addr, fill_data = 0.
REQ-030 SHALL, on reset mid-fill, abandon the fill without further fill pulses; responses arriving after reset are ignored per REQ-023.

Verification (WORDS=4, OFFSET_BITS=4, ADDR_WIDTH=32, DATA_WIDTH=32)
REQ-031 SHALL cover: miss_addr=0x1000_0008, zero-wait memory -> mem_req_addr 0x1000_0008, 0x...0C, 0x...00, 0x...04; four fill pulses in that order; fill_last on 0x1000_0004; miss_ready back high after DONE.
REQ-032 SHALL cover: mem_req_ready low 3 cycles on first request -> mem_req_addr held at 0x1000_0008; no duplicate request.
REQ-033 SHALL cover: mem_rsp_valid=1 data 0xDEAD_BEEF while IDLE -> no fill_valid; state stays IDLE.
REQ-034 SHALL cover: no response for TIMEOUT_CYCLES after the second request -> exactly 1 fill pulse, fill_err pulses once, miss_ready=1 next cycle.
REQ-035 SHALL cover: reset asserted in WAIT_RSP of the third word -> all outputs at reset values next cycle; a response arriving 2 cycles later produces no fill.
REQ-036 SHALL cover: miss_valid held high through a fill with a different miss_addr -> second line fetched only after DONE, starting at its own critical word.
